// File: rtl/switch_debounce_pkg.sv
// switch_debounce_pkg
//   Shared constants and the start-up FSM encoding for the switch
//   debounce block.
//   SwitchBus       : width of the board switch bus (bits 11:0).
//   DebounceDefault : stable-cycle count for 1 ms at the 50 MHz core clock.
//   sw_state_e      : 2-bit start-up FSM encoding (SwFill0/SwFill1/SwLoad/SwRun).
package switch_debounce_pkg;

    localparam int SwitchBus       = 12;
    localparam int DebounceDefault = 50000;
    localparam int DebounceCntW    = 16;

    typedef enum logic [1:0] {
        SwFill0 = 2'd0,
        SwFill1 = 2'd1,
        SwLoad  = 2'd2,
        SwRun   = 2'd3
    } sw_state_e;

endpackage

// File: rtl/switch_debounce_bit.sv
// switch_debounce_bit
//   One switch bit: two-flop synchroniser, stable-level flop, debounce
//   counter and one-cycle change pulse.
//   Ports:
//     clk       in   core clock
//     rst       in   synchronous active-low reset
//     i_switch  in   raw asynchronous switch level
//     i_load    in   copy the synchronised level straight into o_level
//     i_run     in   debounce enable
//     o_level   out  debounced level
//     o_changed out  one-cycle pulse in the cycle o_level takes a new value
module switch_debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DebounceDefault,
    parameter int CNT_W           = DebounceCntW
) (
    input  logic clk,
    input  logic rst,
    input  logic i_switch,
    input  logic i_load,
    input  logic i_run,
    output logic o_level,
    output logic o_changed
);

    localparam logic [CNT_W-1:0] TermCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_changed;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_s1      <= i_switch;
            r_s2      <= r_s1;
            r_changed <= 1'b0;
            if (i_load) begin
                // Initial capture: no debounce, no change pulse.
                r_level <= r_s2;
                r_cnt   <= '0;
            end else if (i_run) begin
                if (r_s2 == r_level) begin
                    // Any return to the accepted level forfeits the count.
                    r_cnt <= '0;
                end else if (r_cnt == TermCnt) begin
                    r_level   <= r_s2;
                    r_cnt     <= '0;
                    r_changed <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_level   = r_level;
    assign o_changed = r_changed;

endmodule

// File: rtl/switch_debounce.sv
// switch_debounce
//   Synchronises and debounces the board switches ahead of the SOPC
//   switch_on port. A start-up FSM holds off until the synchronisers have
//   filled, then loads the current levels without a change pulse.
//   Optional feature macro: SWITCH_IRQ_EN (sticky change interrupt).
//   Ports:
//     clk        in   core clock
//     rst        in   synchronous active-low reset
//     switch_i   in   raw switch levels [WIDTH]
//     switch_o   out  debounced levels [WIDTH]
//     changed_o  out  per-bit one-cycle change pulse [WIDTH]
//     ready_o    out  high while the FSM is in RUN
//     irq_clr_i  in   clears the sticky IRQ (ignored without SWITCH_IRQ_EN)
//     irq_o      out  sticky change IRQ (tied 0 without SWITCH_IRQ_EN)
//
//   state   | meaning
//   SwFill0 | first synchroniser stage filling after reset
//   SwFill1 | second synchroniser stage filling
//   SwLoad  | capture synchronised levels as the initial debounced value
//   SwRun   | normal debouncing; terminal until reset
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH           = SwitchBus,
    parameter int DEBOUNCE_CYCLES = DebounceDefault,
    parameter int CNT_W           = DebounceCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch_i,
    output logic [WIDTH-1:0] switch_o,
    output logic [WIDTH-1:0] changed_o,
    output logic             ready_o,
    input  logic             irq_clr_i,
    output logic             irq_o
);

    sw_state_e r_state;
    sw_state_e w_next_state;
    logic      w_load;
    logic      w_run;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= SwFill0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SwFill0: w_next_state = SwFill1;
            SwFill1: w_next_state = SwLoad;
            SwLoad:  w_next_state = SwRun;
            SwRun:   w_next_state = SwRun;
            default: w_next_state = SwFill0;
        endcase
    end

    always_comb begin
        w_load  = 1'b0;
        w_run   = 1'b0;
        ready_o = 1'b0;
        case (r_state)
            SwLoad: w_load = 1'b1;
            SwRun: begin
                w_run   = 1'b1;
                ready_o = 1'b1;
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk       (clk),
            .rst       (rst),
            .i_switch  (switch_i[g]),
            .i_load    (w_load),
            .i_run     (w_run),
            .o_level   (switch_o[g]),
            .o_changed (changed_o[g])
        );
    end

`ifdef SWITCH_IRQ_EN
    logic r_irq;

    // A new change takes priority over a simultaneous clear so no event is lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else if (|changed_o) begin
            r_irq <= 1'b1;
        end else if (irq_clr_i) begin
            r_irq <= 1'b0;
        end
    end

    assign irq_o = r_irq;
`else
    logic w_unused_irq_clr;
    assign w_unused_irq_clr = irq_clr_i;
    assign irq_o            = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce
//   Bench for switch_debounce with DEBOUNCE_CYCLES=4. Expected change
//   events are queued when stimulus is applied and matched by a negedge
//   monitor whenever changed_o pulses.
module tb_switch_debounce;

    localparam int W  = 12;
    localparam int DB = 4;
`ifdef SWITCH_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic [W-1:0] switch_i  = '0;
    logic         irq_clr_i = 1'b0;
    logic [W-1:0] switch_o;
    logic [W-1:0] changed_o;
    logic         ready_o;
    logic         irq_o;

    switch_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .switch_i  (switch_i),
        .switch_o  (switch_o),
        .changed_o (changed_o),
        .ready_o   (ready_o),
        .irq_clr_i (irq_clr_i),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [W-1:0] ch;
        logic [W-1:0] so;
        int           at;
    } exp_t;

    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && (changed_o !== '0)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse changed_o=%h switch_o=%h cycle=%0d (no change expected)",
                         changed_o, switch_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (changed_o !== e.ch || switch_o !== e.so || cyc !== e.at) begin
                    errors++;
                    $display("FAIL change_event changed_o=%h switch_o=%h cycle=%0d, wanted changed_o=%h switch_o=%h cycle=%0d",
                             changed_o, switch_o, cyc, e.ch, e.so, e.at);
                end
            end
        end
    end

    task automatic test_reset();
        rst      = 1'b0;
        switch_i = 12'd6;
        repeat (3) @(negedge clk);
        checks++;
        if ({switch_o, changed_o, ready_o, irq_o} !== '0) begin
            errors++;
            $display("FAIL reset_state switch_o=%h changed_o=%h ready_o=%b irq_o=%b, wanted all 0",
                     switch_o, changed_o, ready_o, irq_o);
        end
        mon_en = 1'b1;
        rst    = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (ready_o !== (k == 3) || switch_o !== ((k == 3) ? 12'd6 : 12'd0)) begin
                errors++;
                $display("FAIL startup_k%0d ready_o=%b switch_o=%h, wanted ready_o=%b switch_o=%h",
                         k, ready_o, switch_o, (k == 3), (k == 3) ? 12'd6 : 12'd0);
            end
        end
    endtask

    task automatic test_step_bit0();
        switch_i = 12'h007;
        sb.push_back('{12'h001, 12'h007, cyc + DB + 2});
        repeat (DB + 1) @(negedge clk);
        checks++;
        if (switch_o !== 12'h006) begin
            errors++;
            $display("FAIL step_early switch_o=%h, wanted 006", switch_o);
        end
        @(negedge clk);
        checks++;
        if (switch_o !== 12'h007) begin
            errors++;
            $display("FAIL step_on_time switch_o=%h, wanted 007", switch_o);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL step_missing pending=%0d, wanted 0", sb.size());
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 20; k++) begin
            switch_i[3] = ~k[0];
            @(negedge clk);
            checks++;
            if (switch_o !== 12'h007) begin
                errors++;
                $display("FAIL bounce_k%0d switch_o=%h, wanted 007", k, switch_o);
            end
        end
        switch_i[3] = 1'b0;
        repeat (DB + 4) @(negedge clk);
        checks++;
        if (switch_o !== 12'h007) begin
            errors++;
            $display("FAIL bounce_settle switch_o=%h, wanted 007", switch_o);
        end
    endtask

    task automatic test_min_pulse();
        // One cycle short of the debounce window: must be rejected.
        switch_i[7] = 1'b1;
        repeat (DB - 1) @(negedge clk);
        switch_i[7] = 1'b0;
        repeat (DB + 4) @(negedge clk);
        checks++;
        if (switch_o !== 12'h007) begin
            errors++;
            $display("FAIL short_pulse switch_o=%h, wanted 007", switch_o);
        end
        // Exactly the debounce window: accepted, then released again.
        switch_i[7] = 1'b1;
        sb.push_back('{12'h080, 12'h087, cyc + DB + 2});
        sb.push_back('{12'h080, 12'h007, cyc + 2 * DB + 2});
        repeat (DB) @(negedge clk);
        switch_i[7] = 1'b0;
        repeat (DB + 6) @(negedge clk);
        checks++;
        if (sb.size() != 0 || switch_o !== 12'h007) begin
            errors++;
            $display("FAIL exact_pulse pending=%0d switch_o=%h, wanted 0 pending, 007",
                     sb.size(), switch_o);
        end
    endtask

    task automatic test_multi_irq();
        switch_i = 12'h006;
        sb.push_back('{12'h001, 12'h006, cyc + DB + 2});
        repeat (DB + 4) @(negedge clk);
        irq_clr_i = 1'b1;
        @(negedge clk);
        irq_clr_i = 1'b0;
        checks++;
        if (irq_o !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL irq_idle_clear irq_o=%b pending=%0d, wanted 0, 0", irq_o, sb.size());
        end
        switch_i = 12'hF06;
        sb.push_back('{12'hF00, 12'hF06, cyc + DB + 2});
        repeat (DB + 2) @(negedge clk);
        checks++;
        if (irq_o !== 1'b0 || changed_o !== 12'hF00) begin
            errors++;
            $display("FAIL multi_pulse changed_o=%h irq_o=%b, wanted F00, 0", changed_o, irq_o);
        end
        irq_clr_i = 1'b1;
        @(negedge clk);
        irq_clr_i = 1'b0;
        checks++;
        if (irq_o !== IRQ_EN) begin
            errors++;
            $display("FAIL irq_set_wins irq_o=%b, wanted %b", irq_o, IRQ_EN);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (irq_o !== IRQ_EN || switch_o !== 12'hF06) begin
            errors++;
            $display("FAIL irq_sticky irq_o=%b switch_o=%h, wanted %b, F06", irq_o, switch_o, IRQ_EN);
        end
        irq_clr_i = 1'b1;
        @(negedge clk);
        irq_clr_i = 1'b0;
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear irq_o=%b, wanted 0", irq_o);
        end
    endtask

    task automatic test_reset_mid();
        switch_i = 12'hF26;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({switch_o, changed_o, ready_o, irq_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset switch_o=%h changed_o=%h ready_o=%b irq_o=%b, wanted all 0",
                     switch_o, changed_o, ready_o, irq_o);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (ready_o !== (k == 3) || switch_o !== ((k == 3) ? 12'hF26 : 12'h000)) begin
                errors++;
                $display("FAIL reload_k%0d ready_o=%b switch_o=%h, wanted ready_o=%b switch_o=%h",
                         k, ready_o, switch_o, (k == 3), (k == 3) ? 12'hF26 : 12'h000);
            end
        end
        repeat (DB + 4) @(negedge clk);
        checks++;
        if (switch_o !== 12'hF26 || sb.size() != 0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reload_settle switch_o=%h pending=%0d irq_o=%b, wanted F26, 0, 0",
                     switch_o, sb.size(), irq_o);
        end
    endtask

    initial begin
        test_reset();
        test_step_bit0();
        test_bounce();
        test_min_pulse();
        test_multi_irq();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
